// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: turns datapath load/store requests into a wait-stated req/ack bus
// transaction, stalling the core until the access resolves, and formats load data.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misalign,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic             fault_q, fault_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lane_q, lane_d;

  logic             access_s;
  logic             aligned_s;
  logic [3:0]       st_be_s;
  logic [31:0]      st_wdata_s;

  // Select the addressed lane and sign/zero-extend it according to the access type.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (f3)
      3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
      3'b100:  fmt_load = {24'h000000, sh[7:0]};
      3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
      3'b101:  fmt_load = {16'h0000, sh[15:0]};
      default: fmt_load = rdata;
    endcase
  endfunction

  // Request decode: alignment/legality check and store lane placement.
  always_comb begin
    access_s   = mem_read | mem_write;
    aligned_s  = 1'b0;
    st_be_s    = 4'b1111;
    st_wdata_s = wdata;
    case (funct3)
      3'b000, 3'b100: aligned_s = 1'b1;
      3'b001, 3'b101: aligned_s = ~addr[0];
      3'b010:         aligned_s = (addr[1:0] == 2'b00);
      default:        aligned_s = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        st_be_s    = 4'b0001 << addr[1:0];
        st_wdata_s = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be_s    = 4'b0011 << {addr[1], 1'b0};
        st_wdata_s = {2{wdata[15:0]}};
      end
      default: begin
        st_be_s    = 4'b1111;
        st_wdata_s = wdata;
      end
    endcase
  end

  // Next-state and registered-output logic for the IDLE/REQ/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    fault_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (access_s && aligned_s) begin
          state_d     = S_REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = mem_write ? st_be_s : 4'b1111;
          bus_wdata_d = st_wdata_s;
          f3_d        = funct3;
          lane_d      = addr[1:0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // bus_err outranks bus_ack; a faulted load returns zero, a faulted store leaves read_data
        if (bus_err) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          fault_d   = 1'b1;
          if (!bus_we_q) begin
            read_data_d = '0;
          end else begin
            read_data_d = read_data_q;
          end
        end else if (bus_ack) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            read_data_d = fmt_load(f3_q, lane_q, bus_rdata);
          end else begin
            read_data_d = read_data_q;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          fault_d   = 1'b1;
          if (!bus_we_q) begin
            read_data_d = '0;
          end else begin
            read_data_d = read_data_q;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= '0;
      fault_q     <= 1'b0;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      fault_q     <= fault_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
    end
  end

  assign misalign  = (state_q == S_IDLE) && access_s && !aligned_s;
  assign stall     = ((state_q == S_IDLE) && access_s && aligned_s) || (state_q == S_REQ);
  assign fault     = fault_q;
  assign read_data = read_data_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: loads, stores, misalignment, timeout/error faults, reset abort.
module tb_lsu_bus_ctrl;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] read_data;
  logic        stall;
  logic        misalign;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  int n_assert;
  int n_fail;
  int stall_cnt;
  int req_cnt;

  lsu_bus_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .read_data (read_data),
    .stall     (stall),
    .misalign  (misalign),
    .fault     (fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one aligned access already presented in IDLE; response arrives in REQ cycle waits+1.
  task automatic run(input int waits, input logic use_ack, input logic use_err,
                     input logic [31:0] rd, input logic exp_we, input logic [31:0] exp_addr,
                     input logic [3:0] exp_be, input logic chk_wd, input logic [31:0] exp_wd);
    stall_cnt = 0;
    req_cnt   = 0;
    #1;
    if (stall) stall_cnt++;
    tick();
    chk("req_rise", {31'd0, bus_req}, 32'd1);
    chk("bus_we", {31'd0, bus_we}, {31'd0, exp_we});
    chk("bus_addr", bus_addr, exp_addr);
    chk("bus_be", {28'd0, bus_be}, {28'd0, exp_be});
    if (chk_wd) chk("bus_wdata", bus_wdata, exp_wd);
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        bus_ack   = use_ack;
        bus_err   = use_err;
        bus_rdata = rd;
      end
      #1;
      if (stall) stall_cnt++;
      if (bus_req) req_cnt++;
      tick();
    end
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_req", {31'd0, bus_req}, 32'd0);
  endtask

  task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read  = rd_en;
    mem_write = wr_en;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    bus_rdata = 32'h0;
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
    tick();
    tick();
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    reset = 1'b1;
    tick();
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_fault", {31'd0, fault}, 32'd0);
    chk("idle_mis", {31'd0, misalign}, 32'd0);

    // LW with 3 wait cycles
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    run(3, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0);
    chk("lw_stall_cycles", stall_cnt, 32'd5);
    chk("lw_req_cycles", req_cnt, 32'd4);
    chk("lw_data", read_data, 32'hDEADBEEF);
    chk("lw_fault", {31'd0, fault}, 32'd0);
    tick();

    // Byte/half loads with lane select and extension
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    run(0, 1'b1, 1'b0, 32'h80112233, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0);
    chk("lb_stall_cycles", stall_cnt, 32'd2);
    chk("lb_data", read_data, 32'hFFFFFF80);
    tick();
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
    run(1, 1'b1, 1'b0, 32'h80112233, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0);
    chk("lbu_data", read_data, 32'h00000080);
    tick();
    issue(1'b1, 1'b0, 3'b000, 32'h100, 32'h0);
    run(0, 1'b1, 1'b0, 32'h80112233, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0);
    chk("lb_lane0", read_data, 32'h00000033);
    tick();
    issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
    run(0, 1'b1, 1'b0, 32'h80112233, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0);
    chk("lh_data", read_data, 32'hFFFF8011);
    tick();
    issue(1'b1, 1'b0, 3'b101, 32'h102, 32'h0);
    run(0, 1'b1, 1'b0, 32'h80112233, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0);
    chk("lhu_data", read_data, 32'h00008011);
    tick();

    // Stores: lane placement, replication; read_data untouched
    issue(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5);
    run(2, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 4'b0010, 1'b1, 32'hA5A5A5A5);
    chk("sb_rdata_hold", read_data, 32'h00008011);
    tick();
    issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234);
    run(0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 4'b1100, 1'b1, 32'h12341234);
    tick();
    issue(1'b1, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D);
    run(0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 4'b1111, 1'b1, 32'hCAFEF00D);
    chk("sw_rdata_hold", read_data, 32'h00008011);
    tick();

    // Misaligned / illegal accesses
    issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
    #1;
    chk("mis_lw", {31'd0, misalign}, 32'd1);
    chk("mis_lw_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("mis_lw_noreq", {31'd0, bus_req}, 32'd0);
    issue(1'b0, 1'b1, 3'b001, 32'h301, 32'h0);
    #1;
    chk("mis_sh", {31'd0, misalign}, 32'd1);
    chk("mis_sh_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("mis_sh_noreq", {31'd0, bus_req}, 32'd0);
    issue(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
    #1;
    chk("mis_illegal", {31'd0, misalign}, 32'd1);
    tick();
    chk("mis_illegal_noreq", {31'd0, bus_req}, 32'd0);
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("mis_clear", {31'd0, misalign}, 32'd0);
    chk("mis_rdata_hold", read_data, 32'h00008011);

    // Stray ack while idle is ignored
    bus_ack   = 1'b1;
    bus_rdata = 32'h55555555;
    tick();
    bus_ack = 1'b0;
    tick();
    chk("stray_ack_req", {31'd0, bus_req}, 32'd0);
    chk("stray_ack_rdata", read_data, 32'h00008011);

    // Timeout with TIMEOUT=4
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    run(4, 1'b0, 1'b0, 32'h0, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0);
    chk("to_req_cycles", req_cnt, 32'd5);
    chk("to_stall_cycles", stall_cnt, 32'd6);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_rdata", read_data, 32'h0);
    tick();
    chk("to_fault_pulse", {31'd0, fault}, 32'd0);

    // Error beats ack in the same cycle
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    run(0, 1'b1, 1'b0, 32'h11111111, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0);
    chk("pre_err_data", read_data, 32'h11111111);
    tick();
    issue(1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
    run(1, 1'b1, 1'b1, 32'h22222222, 1'b0, 32'h104, 4'b1111, 1'b0, 32'h0);
    chk("err_fault", {31'd0, fault}, 32'd1);
    chk("err_rdata", read_data, 32'h0);
    tick();
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    run(0, 1'b1, 1'b0, 32'h33333333, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0);
    tick();
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'h77777777);
    run(0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h100, 4'b1111, 1'b1, 32'h77777777);
    chk("st_err_fault", {31'd0, fault}, 32'd1);
    chk("st_err_rdata_hold", read_data, 32'h33333333);
    tick();

    // Reset asserted mid-transaction
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    tick();
    chk("rst_mid_req", {31'd0, bus_req}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    mem_read = 1'b0;
    #1;
    chk("rst_mid_req_drop", {31'd0, bus_req}, 32'd0);
    chk("rst_mid_rdata", read_data, 32'h0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    bus_ack   = 1'b1;
    bus_rdata = 32'hABCD1234;
    tick();
    bus_ack = 1'b0;
    tick();
    chk("late_ack_rdata", read_data, 32'h0);
    chk("late_ack_req", {31'd0, bus_req}, 32'd0);
    chk("late_ack_fault", {31'd0, fault}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store unit sitting directly downstream of the core datapath. It consumes the datapath's ALU result (address) and register write data. It drives a multi-cycle req/ack data bus with byte-lane alignment, and returns sign- or zero-extended load data into the datapath's read-data input. A stall output freezes the PC and register file while a bus transaction is outstanding, which lets the single-cycle core tolerate wait-stated memory.

Parameters:
TIMEOUT, 255, max cycles in REQ without bus_ack/bus_err before the access is aborted with a fault
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk; reset==0 resets the block
mem_read  input  1  current instruction is a load
mem_write  input  1  current instruction is a store; wins if both are high
funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  32  byte address from the datapath ALU result
wdata  input  32  store data from the datapath register file port 2
read_data  output  32  formatted load result to the datapath, registered
stall  output  1  high = core must hold PC and suppress reg_write this cycle
misalign  output  1  one-cycle pulse: misaligned address or illegal funct3; no bus access made
fault  output  1  one-cycle pulse in DONE when the access ended by bus_err or timeout
bus_req  output  1  transaction request, registered
bus_we  output  1  1 = write
bus_addr  output  32  {addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_rdata  input  32  read data, valid with bus_ack
bus_ack  input  1  transaction complete
bus_err  input  1  transaction failed; takes priority over bus_ack in the same cycle

Behaviour:
- States: IDLE, REQ, DONE. On reset: state=IDLE, read_data=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, misalign=0, fault=0, counter=0.
- access = mem_read|mem_write. aligned = (H/HU: addr[0]==0), (W: addr[1:0]==0), B/BU always. Illegal funct3 (011, 110, 111) counts as misaligned.
- IDLE, access and aligned: latch we/addr/be/wdata and go to REQ. bus_req goes high the next cycle.
- IDLE, access and not aligned: misalign=1 for that cycle, stall=0, no state change, read_data unchanged.
- REQ: bus_req=1 and all bus outputs held stable. Counter increments each cycle.
  - bus_err: go to DONE with fault.
  - else bus_ack: capture the formatted load (loads only) and go to DONE.
  - else counter==TIMEOUT: go to DONE with fault.
  - bus_req drops in the cycle after the terminating event.
- DONE: stall=0 so the core retires the instruction. Go unconditionally to IDLE. A new access is not evaluated until IDLE, so the same instruction is never reissued. Counter clears.
- stall (combinational) = (IDLE & access & aligned) | REQ. It is low in DONE.
- Latency for W bus wait cycles (ack arrives in the (W+1)th REQ cycle): stall high for W+2 cycles, then the DONE cycle.
- Stores:
  - SB: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - SW: be=1111.
- Loads: select lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W is passed through. bus_be=1111 for loads.
- Fault on a load: read_data=0. Fault on a store: read_data is unchanged.
- read_data holds its value until the next load completes.
- bus_ack/bus_err outside REQ are ignored.
- reset==0 mid-transaction: returns to IDLE at that edge and bus_req=0 the following cycle; the outstanding bus response is ignored.

Test Plan:
1. LW addr=0x100, bus acks after 3 wait cycles with rdata=0xDEADBEEF -> bus_addr=0x100, be=1111; stall high 5 cycles; read_data=0xDEADBEEF in DONE.
2. LB addr=0x103, rdata=0x80112233 -> read_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr=0x102 -> 0x00008011.
3. SB addr=0x201, wdata=0x000000A5 -> bus_we=1, be=0010, bus_wdata=0xA5A5A5A5, bus_addr=0x200. SH addr=0x202 -> be=1100.
4. LW addr=0x102 and SH addr=0x301 -> misalign pulse, stall=0, bus_req stays 0.
5. LW with no ack, TIMEOUT=4 -> bus_req high for 5 cycles then drops; fault pulse; read_data=0. bus_err with bus_ack in the same cycle -> fault.
6. reset=0 asserted during REQ -> IDLE, bus_req=0 next cycle; a late bus_ack is ignored; read_data=0.
